evt_flag_drain: RTL and testbench



---
 rtl/evt_pkg.sv | 28 ++
 rtl/evt_sat_cnt.sv | 35 +++
 rtl/evt_flag_drain.sv | 114 +++++++++++
 tb/tb_evt_flag_drain.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_pkg.sv
// Shared definitions for the event flag drain block.
//   - default widths for the event vector and beat counter
//   - FSM state encoding
//   - saturating increment helper, sized wide enough for any counter here
package evt_pkg;

    localparam int W_DEF  = 8;
    localparam int CW_DEF = 4;
    localparam int SAT_W  = 16;

    localparam logic IDLE_ENC  = 1'b0;
    localparam logic OFFER_ENC = 1'b1;

    typedef enum logic {
        ST_IDLE  = IDLE_ENC,
        ST_OFFER = OFFER_ENC
    } state_t;

    // Increment by one when enabled, holding at max.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                                 input logic             en,
                                                 input logic [SAT_W-1:0] max);
        if (en && (cnt != max))
            return cnt + SAT_W'(1);
        return cnt;
    endfunction

endpackage

// File: rtl/evt_sat_cnt.sv
// CW-bit saturating counter with synchronous load.
//   i_clk, i_rst   : clock, async active-high reset
//   i_load         : load i_load_val (takes priority over increment)
//   i_load_val     : value loaded on i_load
//   i_inc          : increment enable (saturates at 2^CW-1)
//   o_cnt          : current count
module evt_sat_cnt
    import evt_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_inc,
    output logic [CW-1:0] o_cnt
);

    localparam logic [SAT_W-1:0] MAX = SAT_W'((1 << CW) - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else
            r_cnt <= CW'(sat_inc(SAT_W'(r_cnt), i_inc, MAX));
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/evt_flag_drain.sv
// Sticky event-flag collector with a clear-on-read valid/ready drain port.
//   i_clk, i_rst    : clock, async active-high reset
//   i_evt_valid     : event beat present
//   i_evt_data      : event bits ORed into pending flags
//   o_rd_valid      : snapshot available (registered, == state OFFER)
//   i_rd_ready      : consumer accepts snapshot
//   o_rd_data       : snapshot of flags
//   o_rd_count      : nonzero beats merged into snapshot (saturating)
//   o_overrun       : sticky, flag re-set while already pending
//   i_ovr_clr       : write-1-to-clear for o_overrun
//   o_irq           : registered, pending flags or snapshot outstanding
module evt_flag_drain
    import evt_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_evt_valid,
    input  logic [W-1:0]  i_evt_data,
    output logic          o_rd_valid,
    input  logic          i_rd_ready,
    output logic [W-1:0]  o_rd_data,
    output logic [CW-1:0] o_rd_count,
    output logic [W-1:0]  o_overrun,
    input  logic [W-1:0]  i_ovr_clr,
    output logic          o_irq
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_pending;
    logic [W-1:0]  r_rd_data;
    logic [CW-1:0] r_rd_count;
    logic [W-1:0]  r_overrun;
    logic          r_irq;

    logic [W-1:0]  w_ev;
    logic          w_ev_nz;
    logic          w_pend_nz;
    logic          w_load;
    logic [W-1:0]  w_pend_nxt;
    logic [W-1:0]  w_ovr_nxt;
    logic [CW-1:0] w_pend_cnt;

    assign w_ev      = i_evt_valid ? i_evt_data : '0;
    assign w_ev_nz   = |w_ev;
    assign w_pend_nz = |r_pending;

    // A beat arriving on the load edge lands in the freshly cleared
    // register, so nothing is lost and it does not count as overrun.
    assign w_pend_nxt = (w_load ? '0 : r_pending) | w_ev;
    assign w_ovr_nxt  = (r_overrun & ~i_ovr_clr) | (w_ev & r_pending & {W{~w_load}});

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_nz) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Handshake: reload back-to-back if more flags are waiting.
                if (i_rd_ready) begin
                    if (w_pend_nz)
                        w_load = 1'b1;
                    else
                        w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    evt_sat_cnt #(.CW(CW)) u_pend_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val ({{(CW-1){1'b0}}, w_ev_nz}),
        .i_inc      (w_ev_nz),
        .o_cnt      (w_pend_cnt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_rd_data  <= '0;
            r_rd_count <= '0;
            r_overrun  <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pend_nxt;
            r_overrun <= w_ovr_nxt;
            r_irq     <= (|w_pend_nxt) || (w_state_nxt == ST_OFFER);
            if (w_load) begin
                r_rd_data  <= r_pending;
                r_rd_count <= w_pend_cnt;
            end
        end
    end

    assign o_rd_valid = (r_state == ST_OFFER);
    assign o_rd_data  = r_rd_data;
    assign o_rd_count = r_rd_count;
    assign o_overrun  = r_overrun;
    assign o_irq      = r_irq;

endmodule

// File: tb/tb_evt_flag_drain.sv
module tb_evt_flag_drain;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          evt_valid = 1'b0;
    logic [W-1:0]  evt_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [W-1:0]  rd_data;
    logic [CW-1:0] rd_count;
    logic [W-1:0]  overrun;
    logic [W-1:0]  ovr_clr = '0;
    logic          irq;

    int n_chk  = 0;
    int n_pass = 0;

    evt_flag_drain #(.W(W), .CW(CW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_evt_valid (evt_valid),
        .i_evt_data  (evt_data),
        .o_rd_valid  (rd_valid),
        .i_rd_ready  (rd_ready),
        .o_rd_data   (rd_data),
        .o_rd_count  (rd_count),
        .o_overrun   (overrun),
        .i_ovr_clr   (ovr_clr),
        .o_irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a pending flag set, a single-entry snapshot slot
    // and a sticky overrun set. The slot is refilled whenever it is free
    // (empty, or being taken this edge) and flags are waiting.
    logic [W-1:0]  m_pend;
    int            m_cnt;
    logic          m_full;
    logic [W-1:0]  m_data;
    int            m_rcnt;
    logic [W-1:0]  m_ovr;
    logic          m_irq;

    task automatic model_reset();
        m_pend = '0; m_cnt = 0; m_full = 1'b0; m_data = '0;
        m_rcnt = 0; m_ovr = '0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [W-1:0] ev;
        bit nz, taken, take;
        ev    = evt_valid ? evt_data : '0;
        nz    = (ev != 0);
        taken = m_full && rd_ready;
        take  = (!m_full || taken) && (m_pend != 0);
        m_ovr = (m_ovr & ~ovr_clr) | (take ? '0 : (ev & m_pend));
        if (take) begin
            m_data = m_pend;
            m_rcnt = m_cnt;
            m_pend = ev;
            m_cnt  = nz ? 1 : 0;
            m_full = 1'b1;
        end else begin
            m_pend = m_pend | ev;
            m_cnt  = (m_cnt + (nz ? 1 : 0) > CMAX) ? CMAX : m_cnt + (nz ? 1 : 0);
            if (taken) m_full = 1'b0;
        end
        m_irq = (m_pend != 0) || m_full;
    endtask

    // Inputs are changed only at negedge; one call = one rising edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        evt_valid = 1'b0; evt_data = '0; rd_ready = 1'b0; ovr_clr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        evt_valid = 1'b1; evt_data = 8'hFF;
        cyc(); cyc(); cyc();
        n_chk++;
        if (!(rd_valid === 1'b1 && overrun === 8'hFF && irq === 1'b1))
            $display("FAIL reset_pre: got vld=%b ovr=%h irq=%b, want 1 ff 1", rd_valid, overrun, irq);
        else n_pass++;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({rd_valid, rd_data, rd_count, overrun, irq} !== '0)
            $display("FAIL reset_async: got vld=%b data=%h cnt=%h ovr=%h irq=%b, want all 0",
                     rd_valid, rd_data, rd_count, overrun, irq);
        else n_pass++;
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_chk++;
            if (rd_valid !== 1'b0 || irq !== 1'b0)
                $display("FAIL reset_quiet[%0d]: got vld=%b irq=%b, want 0 0", i, rd_valid, irq);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        do_reset();
        evt_valid = 1'b1; evt_data = 8'hAA;
        cyc();
        idle_inputs();
        cyc();
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if ({rd_valid, rd_data, rd_count, irq} !== {1'b1, 8'hAA, 4'h1, 1'b1})
                $display("FAIL single_hold[%0d]: got vld=%b data=%h cnt=%h irq=%b, want 1 aa 1 1",
                         i, rd_valid, rd_data, rd_count, irq);
            else n_pass++;
            if (i < 5) cyc();
        end
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        n_chk++;
        if (rd_valid !== 1'b0 || irq !== 1'b0)
            $display("FAIL single_drain: got vld=%b irq=%b, want 0 0", rd_valid, irq);
        else n_pass++;
    endtask

    task automatic test_accumulate();
        logic [W-1:0] seq [3];
        seq[0] = 8'h01; seq[1] = 8'h00; seq[2] = 8'h10;
        do_reset();
        evt_valid = 1'b1; evt_data = 8'h80;
        cyc();
        idle_inputs();
        cyc();
        for (int i = 0; i < 3; i++) begin
            evt_valid = 1'b1; evt_data = seq[i];
            cyc();
        end
        idle_inputs();
        n_chk++;
        if ({rd_valid, rd_data, rd_count} !== {1'b1, 8'h80, 4'h1})
            $display("FAIL accum_first: got vld=%b data=%h cnt=%h, want 1 80 1", rd_valid, rd_data, rd_count);
        else n_pass++;
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        n_chk++;
        if ({rd_valid, rd_data, rd_count} !== {1'b1, 8'h11, 4'h2})
            $display("FAIL accum_reload: got vld=%b data=%h cnt=%h, want 1 11 2", rd_valid, rd_data, rd_count);
        else n_pass++;
    endtask

    task automatic test_simul_load();
        do_reset();
        evt_valid = 1'b1; evt_data = 8'h55;
        cyc();
        cyc();
        idle_inputs();
        n_chk++;
        if ({rd_valid, rd_data, rd_count, overrun} !== {1'b1, 8'h55, 4'h1, 8'h00})
            $display("FAIL simul_load: got vld=%b data=%h cnt=%h ovr=%h, want 1 55 1 00",
                     rd_valid, rd_data, rd_count, overrun);
        else n_pass++;
        rd_ready = 1'b1;
        cyc();
        n_chk++;
        if ({rd_valid, rd_data, rd_count, overrun} !== {1'b1, 8'h55, 4'h1, 8'h00})
            $display("FAIL simul_kept: got vld=%b data=%h cnt=%h ovr=%h, want 1 55 1 00",
                     rd_valid, rd_data, rd_count, overrun);
        else n_pass++;
        cyc();
        rd_ready = 1'b0;
        n_chk++;
        if (rd_valid !== 1'b0 || irq !== 1'b0)
            $display("FAIL simul_drain: got vld=%b irq=%b, want 0 0", rd_valid, irq);
        else n_pass++;
    endtask

    task automatic test_overrun();
        do_reset();
        evt_valid = 1'b1; evt_data = 8'h80;
        cyc();
        idle_inputs();
        cyc();
        evt_valid = 1'b1; evt_data = 8'h0F;
        cyc();
        evt_data = 8'h03;
        cyc();
        idle_inputs();
        n_chk++;
        if (overrun !== 8'h03)
            $display("FAIL ovr_set: got %h, want 03", overrun);
        else n_pass++;
        ovr_clr = 8'h01;
        cyc();
        n_chk++;
        if (overrun !== 8'h02)
            $display("FAIL ovr_clr: got %h, want 02", overrun);
        else n_pass++;
        ovr_clr = 8'h02; evt_valid = 1'b1; evt_data = 8'h02;
        cyc();
        idle_inputs();
        n_chk++;
        if (overrun !== 8'h02)
            $display("FAIL ovr_set_wins: got %h, want 02", overrun);
        else n_pass++;
        ovr_clr = 8'h02;
        cyc();
        ovr_clr = '0;
        n_chk++;
        if (overrun !== 8'h00)
            $display("FAIL ovr_clr2: got %h, want 00", overrun);
        else n_pass++;
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        evt_valid = 1'b1; evt_data = 8'h0F;
        cyc();
        idle_inputs();
        n_chk++;
        if ({rd_data, overrun} !== {8'h0F, 8'h00})
            $display("FAIL ovr_snapshot_only: got data=%h ovr=%h, want 0f 00", rd_data, overrun);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        evt_valid = 1'b1; evt_data = 8'h40;
        cyc();
        idle_inputs();
        cyc();
        evt_valid = 1'b1; evt_data = 8'h80;
        for (int i = 0; i < 20; i++) cyc();
        idle_inputs();
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        n_chk++;
        if ({rd_valid, rd_data, rd_count} !== {1'b1, 8'h80, 4'hF})
            $display("FAIL saturation: got vld=%b data=%h cnt=%h, want 1 80 f", rd_valid, rd_data, rd_count);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            evt_valid = ($urandom_range(0, 1) == 1);
            evt_data  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            rd_ready  = ($urandom_range(0, 3) == 0);
            ovr_clr   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            cyc();
            n_chk++;
            if ({rd_valid, rd_data, rd_count, overrun, irq} !==
                {m_full, m_data, 4'(m_rcnt), m_ovr, m_irq}) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: got vld=%b data=%h cnt=%h ovr=%h irq=%b, want %b %h %h %h %b",
                             i, rd_valid, rd_data, rd_count, overrun, irq,
                             m_full, m_data, 4'(m_rcnt), m_ovr, m_irq);
                errs++;
            end else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #12 rst = 1'b0;
        test_reset();
        test_single();
        test_accumulate();
        test_simul_load();
        test_overrun();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
